// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding and
// default sizing used by ifetch and its testbench.
package ifetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_e;

  localparam int unsigned DEF_DEPTH    = 4;
  localparam int unsigned DEF_MAX_OUT  = 2;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ifetch_q.sv
// Parameterised synchronous FIFO with flush; used both for the instruction
// queue and for the outstanding-request pc tags.
module ifetch_q #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = data_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) data_q[wr_ptr] <= din;
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: issues halfword fetches, buffers returned
// instructions in order, and handles redirects and fetch faults.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int unsigned    RV       = 32,
  parameter int unsigned    DEPTH    = DEF_DEPTH,
  parameter logic [RV-1:0]  RESET_PC = RV'(DEF_RESET_PC),
  parameter int unsigned    MAX_OUT  = DEF_MAX_OUT
) (
  input  logic          clk,
  input  logic          reset,
  output logic          mem_req,
  output logic [RV-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic          mem_rvalid,
  input  logic [15:0]   mem_rdata,
  input  logic          mem_fault,
  input  logic          ins_ready,
  output logic [15:0]   ins,
  output logic          idone,
  output logic [RV-1:0] ins_pc,
  output logic          ins_fault,
  input  logic          redirect,
  input  logic [RV-1:0] redirect_pc
);

  localparam int unsigned QW  = 16 + RV + 1;
  localparam int unsigned QCW = $clog2(DEPTH + 1);
  localparam int unsigned TCW = $clog2(MAX_OUT + 1);
  localparam int unsigned SW  = $clog2(DEPTH + MAX_OUT + 1) + 1;

  fetch_state_e     state;
  fetch_state_e     state_next;
  logic [RV-1:0]    fetch_pc;
  logic [RV-1:0]    pc_next;
  logic [TCW-1:0]   discard_cnt;
  logic [TCW-1:0]   discard_next;
  logic [SW-1:0]    outstanding;
  logic             resp_take;
  logic             resp_drop;

  logic [QW-1:0]    q_dout;
  logic             q_full;
  logic             q_empty;
  logic [QCW-1:0]   q_count;
  logic [RV-1:0]    tag_dout;
  logic             tag_full;
  logic             tag_empty;
  logic [TCW-1:0]   tag_count;

  // Requests still owed a response: live tags plus those being discarded.
  assign outstanding = SW'(tag_count) + SW'(discard_cnt);
  assign mem_addr    = fetch_pc;
  assign {ins, ins_pc, ins_fault} = q_dout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC & ~RV'(1);
      discard_cnt <= '0;
    end else begin
      state       <= state_next;
      fetch_pc    <= pc_next;
      discard_cnt <= discard_next;
    end
  end

  always_comb begin
    state_next   = state;
    pc_next      = fetch_pc;
    discard_next = discard_cnt;
    mem_req      = 1'b0;
    idone        = 1'b0;
    resp_take    = 1'b0;
    resp_drop    = 1'b0;

    if (!reset) begin
      idone     = !q_empty && ins_ready && !redirect;
      mem_req   = (state == FETCH) && !redirect && !q_full && !tag_full &&
                  (outstanding < SW'(MAX_OUT)) &&
                  ((SW'(q_count) + outstanding) < SW'(DEPTH));
      resp_take = mem_rvalid && !redirect && (discard_cnt == '0) && !tag_empty;
      resp_drop = mem_rvalid && !redirect && (discard_cnt != '0);
    end

    // A response landing in the redirect cycle is dropped immediately, so it
    // is not counted among those still to be discarded.
    if (redirect) begin
      state_next   = FETCH;
      pc_next      = redirect_pc & ~RV'(1);
      discard_next = (mem_rvalid && (outstanding != '0)) ?
                     TCW'(outstanding - SW'(1)) : TCW'(outstanding);
    end else begin
      if (resp_take && mem_fault) state_next = HALT;
      if (resp_drop) discard_next = discard_cnt - TCW'(1);
      if (mem_req && mem_ack) pc_next = fetch_pc + RV'(2);
    end
  end

  ifetch_q #(
    .WIDTH (QW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (resp_take),
    .pop   (idone),
    .flush (redirect),
    .din   ({mem_rdata, tag_dout, mem_fault}),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  ifetch_q #(
    .WIDTH (RV),
    .DEPTH (MAX_OUT)
  ) u_tags (
    .clk   (clk),
    .reset (reset),
    .push  (mem_req && mem_ack),
    .pop   (resp_take),
    .flush (redirect),
    .din   (fetch_pc),
    .dout  (tag_dout),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

endmodule

// File: tb/tb_ifetch.sv
// Testbench for ifetch: directed scenarios with a queue-based reference
// model checked every cycle, plus hand-computed literal expectations.
module tb_ifetch;

  localparam int unsigned RV      = 32;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned MAX_OUT = 2;
  localparam logic [31:0] RST_PC  = 32'h0000_0100;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        mem_fault;
  logic        ins_ready;
  logic [15:0] ins;
  logic        idone;
  logic [31:0] ins_pc;
  logic        ins_fault;
  logic        redirect;
  logic [31:0] redirect_pc;

  typedef struct {
    logic [15:0] ins;
    logic [31:0] pc;
    logic        fault;
  } entry_t;

  entry_t      mq[$];
  logic [31:0] mtags[$];
  int          mdisc;
  bit          mhalt;
  logic [31:0] mpc;

  logic [31:0] pend[$];
  logic [31:0] acc_log[$];
  logic [31:0] done_pc[$];
  logic [15:0] done_ins[$];
  logic        done_flt[$];

  int   checks;
  int   passed;
  int   req_cnt;
  logic last_req;
  logic last_idone;

  logic        rst_v;
  logic        ack_en;
  logic        ready;
  logic        redir;
  logic        hold;
  logic [31:0] redir_pc;
  logic [31:0] fault_addr;

  ifetch #(
    .RV       (RV),
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC),
    .MAX_OUT  (MAX_OUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .mem_fault   (mem_fault),
    .ins_ready   (ins_ready),
    .ins         (ins),
    .idone       (idone),
    .ins_pc      (ins_pc),
    .ins_fault   (ins_fault),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: address 0x104 deliberately holds 0x0000.
  function automatic logic [15:0] mem_word(input logic [31:0] a);
    return a[15:0] ^ 16'h0104;
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    return (i < acc_log.size()) ? acc_log[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] done_pc_at(input int i);
    return (i < done_pc.size()) ? done_pc[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [15:0] done_ins_at(input int i);
    return (i < done_ins.size()) ? done_ins[i] : 16'hDEAD;
  endfunction

  function automatic logic done_flt_at(input int i);
    return (i < done_flt.size()) ? done_flt[i] : 1'bx;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic clear_logs();
    acc_log.delete();
    done_pc.delete();
    done_ins.delete();
    done_flt.delete();
  endtask

  // One clock cycle: drive inputs, compare against the model, then advance
  // the memory environment and the model as if the clock edge happened.
  task automatic applyStimulus();
    logic   exp_req;
    logic   exp_idone;
    entry_t e;
    @(negedge clk);
    reset       = rst_v;
    mem_ack     = ack_en;
    ins_ready   = ready;
    redirect    = redir;
    redirect_pc = redir_pc;
    if (!hold && pend.size() > 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(pend[0]);
      mem_fault  = (pend[0] == fault_addr);
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 16'h0000;
      mem_fault  = 1'b0;
    end
    #1;

    if (rst_v) begin
      exp_req   = 1'b0;
      exp_idone = 1'b0;
    end else begin
      exp_req   = !mhalt && !redir &&
                  ((mtags.size() + mdisc) < MAX_OUT) &&
                  ((mq.size() + mtags.size() + mdisc) < DEPTH);
      exp_idone = (mq.size() > 0) && ready && !redir;
    end

    checkOutput("mem_req", mem_req, exp_req);
    if (exp_req) checkOutput("mem_addr", mem_addr, mpc);
    checkOutput("idone", idone, exp_idone);
    if (exp_idone) begin
      checkOutput("ins", ins, mq[0].ins);
      checkOutput("ins_pc", ins_pc, mq[0].pc);
      checkOutput("ins_fault", ins_fault, mq[0].fault);
    end

    last_req   = mem_req;
    last_idone = idone;
    if (mem_req) req_cnt++;
    if (mem_req && mem_ack) acc_log.push_back(mem_addr);
    if (idone) begin
      done_pc.push_back(ins_pc);
      done_ins.push_back(ins);
      done_flt.push_back(ins_fault);
    end

    if (rst_v) pend.delete();
    else begin
      if (mem_rvalid) void'(pend.pop_front());
      if (mem_req && mem_ack) pend.push_back(mem_addr);
    end

    if (rst_v) begin
      mq.delete();
      mtags.delete();
      mdisc = 0;
      mhalt = 0;
      mpc   = RST_PC;
    end else if (redir) begin
      mdisc = int'(mtags.size()) + mdisc - (mem_rvalid ? 1 : 0);
      if (mdisc < 0) mdisc = 0;
      mq.delete();
      mtags.delete();
      mhalt = 0;
      mpc   = redir_pc & 32'hFFFF_FFFE;
    end else begin
      if (exp_idone) void'(mq.pop_front());
      if (mem_rvalid) begin
        if (mdisc > 0) mdisc--;
        else if (mtags.size() > 0) begin
          e.ins   = mem_rdata;
          e.pc    = mtags.pop_front();
          e.fault = mem_fault;
          mq.push_back(e);
          if (mem_fault) mhalt = 1;
        end
      end
      if (exp_req && mem_ack) begin
        mtags.push_back(mpc);
        mpc = mpc + 32'd2;
      end
    end
  endtask

  initial begin
    checks = 0; passed = 0; req_cnt = 0;
    mdisc = 0; mhalt = 0; mpc = RST_PC;
    rst_v = 1'b1; ack_en = 1'b1; ready = 1'b1; redir = 1'b0; hold = 1'b0;
    redir_pc = 32'h0; fault_addr = 32'h1;
    reset = 1'b1; mem_ack = 1'b1; ins_ready = 1'b1; redirect = 1'b0;
    redirect_pc = 32'h0; mem_rvalid = 1'b0; mem_rdata = 16'h0; mem_fault = 1'b0;

    repeat (2) applyStimulus();
    checkOutput("reset_mem_req", last_req, 1'b0);
    checkOutput("reset_idone", last_idone, 1'b0);

    // Streaming fetch from RESET_PC.
    rst_v = 1'b0;
    clear_logs();
    repeat (10) applyStimulus();
    checkOutput("stream_addr0", acc_at(0), 32'h100);
    checkOutput("stream_addr1", acc_at(1), 32'h102);
    checkOutput("stream_addr2", acc_at(2), 32'h104);
    checkOutput("stream_addr3", acc_at(3), 32'h106);
    checkOutput("stream_pc0", done_pc_at(0), 32'h100);
    checkOutput("stream_ins0", done_ins_at(0), 16'h0004);
    checkOutput("zero_ins_pc", done_pc_at(2), 32'h104);
    checkOutput("zero_ins", done_ins_at(2), 16'h0000);

    // Back-pressure: queue fills to DEPTH and requests stop.
    ready = 1'b0;
    clear_logs();
    repeat (20) applyStimulus();
    checkOutput("stall_mem_req", last_req, 1'b0);
    checkOutput("stall_idone_cnt", done_pc.size(), 0);
    ready = 1'b1;
    clear_logs();
    repeat (4) applyStimulus();
    checkOutput("release_cnt", done_pc.size(), 4);
    checkOutput("release_pc0", done_pc_at(0), 32'h110);
    checkOutput("release_pc1", done_pc_at(1), 32'h112);
    checkOutput("release_pc2", done_pc_at(2), 32'h114);
    checkOutput("release_pc3", done_pc_at(3), 32'h116);
    repeat (4) applyStimulus();

    // Redirect with two responses still in flight.
    hold = 1'b1;
    repeat (3) applyStimulus();
    redir = 1'b1; redir_pc = 32'h2001;
    clear_logs();
    applyStimulus();
    checkOutput("redir_no_req", last_req, 1'b0);
    redir = 1'b0; hold = 1'b0;
    repeat (8) applyStimulus();
    checkOutput("redir_addr0", acc_at(0), 32'h2000);
    checkOutput("redir_pc0", done_pc_at(0), 32'h2000);
    checkOutput("redir_ins0", done_ins_at(0), 16'h2104);

    // Fetch fault at 0x108 halts fetching until a redirect.
    fault_addr = 32'h108;
    redir = 1'b1; redir_pc = 32'h100;
    clear_logs();
    applyStimulus();
    redir = 1'b0;
    repeat (8) applyStimulus();
    checkOutput("fault_pc0", done_pc_at(0), 32'h100);
    checkOutput("fault_flt0", done_flt_at(0), 1'b0);
    checkOutput("fault_pc4", done_pc_at(4), 32'h108);
    checkOutput("fault_flt4", done_flt_at(4), 1'b1);
    req_cnt = 0;
    repeat (8) applyStimulus();
    checkOutput("halt_req_cnt", req_cnt, 0);
    fault_addr = 32'h1;
    redir = 1'b1; redir_pc = 32'h40;
    clear_logs();
    applyStimulus();
    redir = 1'b0;
    repeat (6) applyStimulus();
    checkOutput("resume_addr0", acc_at(0), 32'h40);
    checkOutput("resume_pc0", done_pc_at(0), 32'h40);
    checkOutput("resume_ins0", done_ins_at(0), 16'h0144);

    // Address wrap at the top of the address space.
    redir = 1'b1; redir_pc = 32'hFFFF_FFFC;
    clear_logs();
    applyStimulus();
    redir = 1'b0;
    repeat (8) applyStimulus();
    checkOutput("wrap_addr1", acc_at(1), 32'hFFFF_FFFE);
    checkOutput("wrap_addr2", acc_at(2), 32'h0000_0000);
    checkOutput("wrap_pc2", done_pc_at(2), 32'h0000_0000);
    checkOutput("wrap_ins2", done_ins_at(2), 16'h0104);

    // Redirect coinciding with a response and a ready core.
    redir = 1'b1; redir_pc = 32'h300;
    clear_logs();
    applyStimulus();
    checkOutput("coinc_idone", last_idone, 1'b0);
    redir = 1'b0;
    applyStimulus();
    checkOutput("coinc_next_idone", last_idone, 1'b0);
    repeat (5) applyStimulus();
    checkOutput("coinc_pc0", done_pc_at(0), 32'h300);

    // Reset in the middle of a running stream.
    rst_v = 1'b1;
    applyStimulus();
    checkOutput("midreset_req", last_req, 1'b0);
    checkOutput("midreset_idone", last_idone, 1'b0);
    applyStimulus();
    rst_v = 1'b0;
    clear_logs();
    repeat (5) applyStimulus();
    checkOutput("midreset_addr0", acc_at(0), 32'h100);
    checkOutput("midreset_pc0", done_pc_at(0), 32'h100);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RV, default 32, meaning address/register width.
REQ-002 Parameter DEPTH, default 4, meaning instruction queue entries (power of 2, >=2).
REQ-003 Parameter RESET_PC, default 0, meaning first fetch address after reset.
REQ-004 Parameter MAX_OUT, default 2, meaning maximum outstanding memory requests.
REQ-005 clk  in  1  sole clock; all state updates on posedge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 mem_req  out  1  fetch request valid.
REQ-008 mem_addr  out  RV  halfword-aligned fetch address, bit 0 always 0.
REQ-009 mem_ack  in  1  request accepted this cycle, only meaningful while mem_req=1.
REQ-010 mem_rvalid  in  1  read data returned, in request order.
REQ-011 mem_rdata  in  16  returned instruction halfword.
REQ-012 mem_fault  in  1  fetch fault, qualified by mem_rvalid.
REQ-013 ins_ready  in  1  core can accept an instruction this cycle.
REQ-014 ins  out  16  instruction word to decoder.
REQ-015 idone  out  1  ins/ins_pc/ins_fault valid and consumed this cycle.
REQ-016 ins_pc  out  RV  address of ins.
REQ-017 ins_fault  out  1  entry carries a fetch fault; decoder side raises the trap.
REQ-018 redirect  in  1  branch/jump/trap taken; restart fetch at redirect_pc.
REQ-019 redirect_pc  in  RV  new fetch address; bit 0 ignored.

Function
REQ-020 Queue entry SHALL hold {ins, pc, fault}; FIFO order, DEPTH entries.
REQ-021 idone SHALL equal (queue not empty) && ins_ready && !redirect; head pops the cycle idone=1.
REQ-022 ins/ins_pc/ins_fault SHALL reflect queue head combinationally; value is don't-care when idone=0.
REQ-023 mem_req SHALL assert in state FETCH when outstanding < MAX_OUT and (occupancy + outstanding) < DEPTH.
REQ-024 On mem_req && mem_ack, fetch pc SHALL advance by 2 and outstanding increment; pc wraps modulo 2^RV.
REQ-025 On mem_rvalid not discarded, entry {mem_rdata, pc of that request, mem_fault} SHALL push; push never overflows (guaranteed by REQ-023).
REQ-026 Simultaneous push and pop SHALL both occur; occupancy unchanged.
REQ-027 A per-request pc tag FIFO of MAX_OUT entries SHALL track addresses of outstanding requests.
REQ-028 States: FETCH, HALT. Reset -> FETCH at RESET_PC.
REQ-029 FETCH -> HALT when a faulting entry is pushed; HALT issues no requests, still drains queue.
REQ-030 redirect (any state) SHALL: flush queue, set fetch pc = {redirect_pc[RV-1:1],0}, set discard count = outstanding (minus responses arriving that cycle), enter FETCH.
REQ-031 Responses while discard count >0 SHALL be dropped and decrement it; a new request is not issued in the redirect cycle.
REQ-032 redirect and mem_rvalid in same cycle: response dropped; redirect and ins_ready: no idone.
REQ-033 Instruction 0x0000 SHALL pass through unmodified (trap decided downstream).
REQ-034 Latency: mem_rvalid in cycle N -> idone possible in cycle N+1.

Reset
REQ-035 reset SHALL clear queue, outstanding, discard count; mem_req=0, idone=0, pc=RESET_PC, state=FETCH; reset mid-transaction drops all in-flight responses (memory also reset).
REQ-036 Queue data arrays need no reset.

Structure
REQ-037 Shared package SHALL hold state encoding and RESET_PC/DEPTH/MAX_OUT defaults.
REQ-038 One sub-module ifetch_q (parameterised synchronous FIFO, push/pop/flush, full/empty) SHALL implement the queue.

Verification
REQ-039 Reset, RESET_PC=0x100, mem_ack=1, 1-cycle rvalid, ins_ready=1 -> mem_addr 0x100,0x102,0x104...; idone with ins_pc 0x100 first.
REQ-040 ins_ready=0 for 20 cycles -> exactly DEPTH entries buffered, mem_req low; release -> 4 idone consecutive, pcs in order.
REQ-041 Two outstanding, redirect to 0x2001 -> both old responses dropped, next mem_addr 0x2000, first ins_pc 0x2000.
REQ-042 mem_fault on 0x108 -> entry popped with ins_fault=1, no further mem_req until redirect to 0x40 resumes at 0x40.
REQ-043 Fetch pc 0xFFFFFFFE -> next mem_addr 0x00000000.
REQ-044 redirect coincident with mem_rvalid and ins_ready -> no push, no idone, queue empty next cycle.
